// File: rtl/ifid_reg.sv
// ifid_reg: IF/ID pipeline register with flush > stall > load priority and an EMPTY/RUN/HOLD FSM.
// Define IFID_PERF_EN to add saturating stall_cnt / flush_cnt event counters.
module ifid_reg #(
    parameter logic [31:0] NOP_INST = 32'h0000_0000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             stall,
    input  logic             flush,
    input  logic [31:0]      pc4_in,
    input  logic [31:0]      inst_in,
    output logic [31:0]      pc4_out,
    output logic [31:0]      inst_out,
    output logic             valid_out,
    output logic [1:0]       state_out
`ifdef IFID_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY = 2'b00, RUN = 2'b01, HOLD = 2'b10} state_e;

    state_e      state_q, state_d;
    logic [31:0] pc4_q, pc4_d, inst_q, inst_d;

    assign valid_out = (state_q == RUN) || (state_q == HOLD);
    assign state_out = state_q;
    assign pc4_out   = pc4_q;
    assign inst_out  = inst_q;

    always_comb begin
        state_d = EMPTY;
        pc4_d   = flush ? 32'h0 : (stall ? pc4_q : pc4_in);
        inst_d  = flush ? NOP_INST : (stall ? inst_q : inst_in);
        // The illegal encoding 2'b11 is not valid, so it always falls back to EMPTY.
        if (!flush && state_q != 2'b11)
            state_d = !stall ? RUN : (valid_out ? HOLD : EMPTY);
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= EMPTY;
            pc4_q   <= 32'h0;
            inst_q  <= NOP_INST;
        end else begin
            state_q <= state_d;
            pc4_q   <= pc4_d;
            inst_q  <= inst_d;
        end
    end

`ifdef IFID_PERF_EN
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall && !flush && !(&stall_cnt_q))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (flush && !(&flush_cnt_q))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end
`else
    if (CNT_W == 0) begin : g_bad_cnt_w
        $error("CNT_W must be at least 1");
    end
`endif
endmodule

// File: doc/ifid_reg.md
IFID_REG -- requirements
Module: ifid_reg

Interface
REQ-001 Parameter NOP_INST, default 32'h0000_0000, is the instruction word inserted on a flush bubble.
REQ-002 Parameter CNT_W, default 16, is the width of each performance counter.
REQ-003 clk  input  1  is the single clock; all state SHALL update on its rising edge.
REQ-004 clr  input  1  is the asynchronous active-high reset.
REQ-005 stall  input  1  is the hold request from the hazard unit, the same signal that freezes the PC register.
REQ-006 flush  input  1  is the squash request from a taken branch or jump.
REQ-007 pc4_in  input  32  is the PC+4 of the fetched instruction.
REQ-008 inst_in  input  32  is the instruction word from instruction memory.
REQ-009 pc4_out  output  32  is the registered PC+4 to decode.
REQ-010 inst_out  output  32  is the registered instruction to decode.
REQ-011 valid_out  output  1  is high when inst_out holds a real fetched instruction.
REQ-012 state_out  output  2  is the current FSM state encoding.
REQ-013 stall_cnt  output  CNT_W  is the count of stall cycles; present only with IFID_PERF_EN.
REQ-014 flush_cnt  output  CNT_W  is the count of flush events; present only with IFID_PERF_EN.

Function
REQ-015 The FSM SHALL have three states: EMPTY=2'b00, RUN=2'b01, HOLD=2'b10; 2'b11 SHALL be unreachable and SHALL recover to EMPTY on the next edge.
REQ-016 Priority on each edge SHALL be flush > stall > load.
REQ-017 On flush: inst_out<=NOP_INST, pc4_out<=0, valid_out<=0, next state EMPTY, regardless of stall.
REQ-018 On stall without flush: pc4_out, inst_out and valid_out SHALL hold; next state HOLD if valid_out=1, otherwise EMPTY.
REQ-019 On load (no stall, no flush): pc4_out<=pc4_in, inst_out<=inst_in, valid_out<=1, next state RUN.
REQ-020 Latency: inputs SHALL appear on the outputs exactly one clk edge after capture, with no combinational path from input to output.
REQ-021 HOLD to RUN SHALL occur on the first edge where stall=0 and flush=0; HOLD to EMPTY on flush.
REQ-022 A flush arriving in HOLD SHALL discard the held instruction, which is never re-presented.
REQ-023 valid_out SHALL equal 1 exactly when state is RUN or HOLD.

Reset
REQ-024 While clr=1: pc4_out=0, inst_out=NOP_INST, valid_out=0, state EMPTY, counters=0, independent of clk.
REQ-025 Reset asserted mid-stall or mid-flush SHALL win immediately; the first load after clr falls SHALL capture inputs normally.

Configuration
REQ-026 Macro IFID_PERF_EN, when defined, SHALL compile in stall_cnt and flush_cnt.
REQ-027 stall_cnt SHALL increment on every edge where stall=1 and flush=0; flush_cnt SHALL increment on every edge where flush=1.
REQ-028 Both counters SHALL saturate at all-ones and never wrap.
REQ-029 Without IFID_PERF_EN, the counter ports and their logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Reset: clr=1 at t=3ns, mid-cycle -> outputs 0 / 32'h0 / 0 immediately and state_out=00.
REQ-031 Load: pc4_in=32'h0000_0004, inst_in=32'h2008_0005 -> next edge gives pc4_out=4, inst_out=32'h2008_0005, valid_out=1, state 01.
REQ-032 Stall: stall=1 for 3 edges while inputs change to 32'hDEAD_BEEF -> outputs hold 32'h2008_0005, state 10, stall_cnt=3.
REQ-033 Flush overriding stall: stall=1 and flush=1 together -> inst_out=NOP_INST, valid_out=0, state 00, flush_cnt+1, stall_cnt unchanged.
REQ-034 Saturation: with IFID_PERF_EN and CNT_W=4, stall held for 20 edges -> stall_cnt=4'hF.
REQ-035 Release: after HOLD, stall=0 with inst_in=32'h0000_0020 -> inst_out=32'h0000_0020, state 01 in one edge.
